// File: rtl/axis_square_pipe.sv
// axis_square_pipe: AXI-Stream squaring stage for the QRS-detection chain.
// Squares each signed input sample, then shifts it right and saturates it.
// All stages advance together, so the stage runs at full throughput and
// accepts back-pressure from downstream.
// Optional tlast sideband: define AXIS_SQUARE_TLAST_EN.
module axis_square_pipe #(
  parameter int DATA_W      = 16,
  parameter int OUT_W       = 32,
  parameter int SHIFT       = 0,
  parameter int PIPE_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              sat_flag,
  input  logic              sat_clr
`ifdef AXIS_SQUARE_TLAST_EN
  ,
  input  logic              s_axis_tlast,
  output logic              m_axis_tlast
`endif
);

  localparam int SQ_W = 2 * DATA_W;
  // One more than the largest representable output, held at SQ_W+1 bits so
  // the comparison also works when OUT_W == SQ_W and can never saturate.
  localparam logic [SQ_W:0] LIMIT = {{SQ_W{1'b0}}, 1'b1} << OUT_W;

  logic                     adv;
  logic signed [DATA_W-1:0] din;
  logic signed [SQ_W-1:0]   sq_full;
  logic [SQ_W-1:0]          last_sq;
  logic                     last_v;
  logic [SQ_W-1:0]          sh;
  logic                     sat_now;
  logic [OUT_W-1:0]         res;
  logic                     out_v;
  logic                     out_sat;
  logic [OUT_W-1:0]         out_d;
  logic                     sat_q;

  // The whole pipeline moves only when the output register is empty or
  // being drained.
  assign adv           = !out_v || m_axis_tready;
  assign s_axis_tready = adv;

  assign din     = s_axis_tdata;
  assign sq_full = SQ_W'(din) * SQ_W'(din);

  generate
    if (PIPE_STAGES == 1) begin : g_single
      assign last_sq = sq_full;
      assign last_v  = s_axis_tvalid;
    end else begin : g_multi
      logic [SQ_W-1:0]        sq_pipe [PIPE_STAGES-1];
      logic [PIPE_STAGES-2:0] v_pipe;

      // The multiply result and valid bits move forward through the middle stages.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_pipe <= '0;
          for (int unsigned i = 0; i < PIPE_STAGES - 1; i++) begin
            sq_pipe[i] <= '0;
          end
        end else if (adv) begin
          sq_pipe[0] <= sq_full;
          v_pipe[0]  <= s_axis_tvalid;
          for (int unsigned i = 1; i < PIPE_STAGES - 1; i++) begin
            sq_pipe[i] <= sq_pipe[i-1];
            v_pipe[i]  <= v_pipe[i-1];
          end
        end
      end

      assign last_sq = sq_pipe[PIPE_STAGES-2];
      assign last_v  = v_pipe[PIPE_STAGES-2];
    end
  endgenerate

  // The last stage shifts the square, then clamps it to the output width.
  always_comb begin
    sh      = last_sq >> SHIFT;
    sat_now = {1'b0, sh} >= LIMIT;
    res     = sat_now ? '1 : sh[OUT_W-1:0];
  end

  // Output register stage; it holds its contents while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v   <= 1'b0;
      out_d   <= '0;
      out_sat <= 1'b0;
    end else if (adv) begin
      out_v   <= last_v;
      out_d   <= res;
      out_sat <= sat_now;
    end
  end

  // Sticky saturation flag; a saturated transfer takes priority over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (out_v && m_axis_tready && out_sat) begin
      sat_q <= 1'b1;
    end else if (sat_clr) begin
      sat_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = out_v;
  assign m_axis_tdata  = out_d;
  assign sat_flag      = sat_q;

`ifdef AXIS_SQUARE_TLAST_EN
  logic [PIPE_STAGES-1:0] last_pipe;

  // tlast follows its beat through every stage. Bubbles carry tlast as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pipe <= '0;
    end else if (adv) begin
      last_pipe[0] <= s_axis_tvalid && s_axis_tlast;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign m_axis_tlast = last_pipe[PIPE_STAGES-1];
`endif

endmodule

// File: tb/tb_axis_square_pipe.sv
// Directed self-checking bench for axis_square_pipe.
// It uses three instances: the default configuration, a 24-bit output that
// saturates, and a single-stage pipe with SHIFT=8.
module tb_axis_square_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  logic        d_sv, d_sr, d_mv, d_mr, d_flag, d_clr, d_sl, d_ml;
  logic [15:0] d_sd;
  logic [31:0] d_md;
  logic        s_sv, s_sr, s_mv, s_mr, s_flag, s_clr, s_sl, s_ml;
  logic [15:0] s_sd;
  logic [23:0] s_md;
  logic        h_sv, h_sr, h_mv, h_mr, h_flag, h_clr, h_sl, h_ml;
  logic [15:0] h_sd;
  logic [31:0] h_md;

  axis_square_pipe u_def (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(d_sv), .s_axis_tready(d_sr), .s_axis_tdata(d_sd),
    .m_axis_tvalid(d_mv), .m_axis_tready(d_mr), .m_axis_tdata(d_md),
    .sat_flag(d_flag), .sat_clr(d_clr)
`ifdef AXIS_SQUARE_TLAST_EN
    , .s_axis_tlast(d_sl), .m_axis_tlast(d_ml)
`endif
  );

  axis_square_pipe #(.DATA_W(16), .OUT_W(24), .SHIFT(0), .PIPE_STAGES(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_sv), .s_axis_tready(s_sr), .s_axis_tdata(s_sd),
    .m_axis_tvalid(s_mv), .m_axis_tready(s_mr), .m_axis_tdata(s_md),
    .sat_flag(s_flag), .sat_clr(s_clr)
`ifdef AXIS_SQUARE_TLAST_EN
    , .s_axis_tlast(s_sl), .m_axis_tlast(s_ml)
`endif
  );

  axis_square_pipe #(.DATA_W(16), .OUT_W(32), .SHIFT(8), .PIPE_STAGES(1)) u_shf (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(h_sv), .s_axis_tready(h_sr), .s_axis_tdata(h_sd),
    .m_axis_tvalid(h_mv), .m_axis_tready(h_mr), .m_axis_tdata(h_md),
    .sat_flag(h_flag), .sat_clr(h_clr)
`ifdef AXIS_SQUARE_TLAST_EN
    , .s_axis_tlast(h_sl), .m_axis_tlast(h_ml)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (d_mv !== 1'b0 || d_md !== 32'd0 || d_flag !== 1'b0) begin
      $display("FAIL reset_def: got v=%b d=%0d f=%b, want v=0 d=0 f=0", d_mv, d_md, d_flag);
      errors++;
    end
    checks++;
    if (d_sr !== 1'b1) begin
      $display("FAIL reset_ready: got %b want 1", d_sr);
      errors++;
    end
    checks++;
    if (s_mv !== 1'b0 || s_flag !== 1'b0 || h_mv !== 1'b0 || h_md !== 32'd0) begin
      $display("FAIL reset_others: got sv=%b sf=%b hv=%b hd=%0d, want 0 0 0 0", s_mv, s_flag, h_mv, h_md);
      errors++;
    end
`ifdef AXIS_SQUARE_TLAST_EN
    checks++;
    if (d_ml !== 1'b0) begin
      $display("FAIL reset_tlast: got %b want 0", d_ml);
      errors++;
    end
`endif
    step;
    step;
    rst_n = 1'b1;
    step;
  endtask

  // Values 1..10 with a one-cycle gap after each; the output lags by 2 cycles.
  task automatic test_gaps;
    for (int i = 1; i <= 10; i++) begin
      d_sv = 1'b1;
      d_sd = 16'(i);
      d_sl = (i == 10);
      step;
      checks++;
      if (d_mv !== 1'b0) begin
        $display("FAIL gaps_early[%0d]: got v=%b want v=0", i, d_mv);
        errors++;
      end
      d_sv = 1'b0;
      d_sl = 1'b0;
      step;
      checks++;
      if (d_mv !== 1'b1 || d_md !== 32'(i * i)) begin
        $display("FAIL gaps_out[%0d]: got v=%b d=%0d, want v=1 d=%0d", i, d_mv, d_md, i * i);
        errors++;
      end
`ifdef AXIS_SQUARE_TLAST_EN
      checks++;
      if (d_ml !== (i == 10)) begin
        $display("FAIL gaps_tlast[%0d]: got %b want %b", i, d_ml, (i == 10));
        errors++;
      end
`endif
    end
    checks++;
    if (d_flag !== 1'b0) begin
      $display("FAIL gaps_sat: got %b want 0", d_flag);
      errors++;
    end
  endtask

  // Values -1..-10 and then -32768, one per cycle.
  task automatic test_back_to_back;
    logic [31:0] expv [11];
    for (int k = 0; k < 10; k++) expv[k] = 32'((k + 1) * (k + 1));
    expv[10] = 32'h4000_0000;
    for (int k = 0; k <= 10; k++) begin
      d_sv = 1'b1;
      d_sd = (k < 10) ? 16'(-(k + 1)) : 16'h8000;
      step;
      if (k >= 1) begin
        checks++;
        if (d_mv !== 1'b1 || d_md !== expv[k-1] || d_sr !== 1'b1) begin
          $display("FAIL b2b[%0d]: got v=%b d=%0h r=%b, want v=1 d=%0h r=1", k - 1, d_mv, d_md, d_sr, expv[k-1]);
          errors++;
        end
      end
    end
    d_sv = 1'b0;
    step;
    checks++;
    if (d_mv !== 1'b1 || d_md !== 32'h4000_0000) begin
      $display("FAIL b2b_mostneg: got v=%b d=%0h, want v=1 d=40000000", d_mv, d_md);
      errors++;
    end
    step;
    checks++;
    if (d_mv !== 1'b0) begin
      $display("FAIL b2b_drain: got v=%b want 0", d_mv);
      errors++;
    end
  endtask

  // Values 5,6,7 with downstream ready held low for cycles 3..6.
  task automatic test_stall;
    int unsigned src [4];
    int unsigned got [$];
    int sent;
    src[0] = 5; src[1] = 6; src[2] = 7; src[3] = 0;
    sent = 0;
    for (int c = 0; c < 12; c++) begin
      d_mr = !(c >= 3 && c < 7);
      d_sv = (sent < 3);
      d_sd = 16'(src[sent]);
      #2;
      if (!d_mr) begin
        checks++;
        if (d_mv !== 1'b1 || d_sr !== 1'b0 || d_md !== 32'd36) begin
          $display("FAIL stall_hold[%0d]: got v=%b r=%b d=%0d, want v=1 r=0 d=36", c, d_mv, d_sr, d_md);
          errors++;
        end
      end
      if (d_mv && d_mr) got.push_back(d_md);
      if (d_sv && d_sr) sent++;
      step;
    end
    d_sv = 1'b0;
    d_mr = 1'b1;
    checks++;
    if (got.size() != 3) begin
      $display("FAIL stall_count: got %0d beats want 3", got.size());
      errors++;
    end else begin
      checks++;
      if (got[0] != 25 || got[1] != 36 || got[2] != 49) begin
        $display("FAIL stall_order: got %0d,%0d,%0d want 25,36,49", got[0], got[1], got[2]);
        errors++;
      end
    end
  endtask

  // OUT_W=24: 4095^2 fits in 24 bits; 4096^2 = 2^24 saturates.
  task automatic test_saturation;
    s_sv = 1'b1; s_sd = 16'd4095; step;
    s_sv = 1'b0; step;
    checks++;
    if (s_mv !== 1'b1 || s_md !== 24'hFFE001) begin
      $display("FAIL sat_4095: got v=%b d=%0h, want v=1 d=ffe001", s_mv, s_md);
      errors++;
    end
    step;
    checks++;
    if (s_flag !== 1'b0) begin
      $display("FAIL sat_flag_4095: got %b want 0", s_flag);
      errors++;
    end
    s_sv = 1'b1; s_sd = 16'd4096; step;
    s_sv = 1'b0; step;
    checks++;
    if (s_mv !== 1'b1 || s_md !== 24'hFFFFFF || s_flag !== 1'b0) begin
      $display("FAIL sat_4096: got v=%b d=%0h f=%b, want v=1 d=ffffff f=0", s_mv, s_md, s_flag);
      errors++;
    end
    step;
    checks++;
    if (s_flag !== 1'b1) begin
      $display("FAIL sat_flag_set: got %b want 1", s_flag);
      errors++;
    end
    s_clr = 1'b1; step;
    s_clr = 1'b0;
    checks++;
    if (s_flag !== 1'b0) begin
      $display("FAIL sat_clear: got %b want 0", s_flag);
      errors++;
    end
    s_sv = 1'b1; s_sd = 16'd4096; step;
    s_sv = 1'b0; step;
    s_clr = 1'b1; step;
    s_clr = 1'b0;
    checks++;
    if (s_flag !== 1'b1) begin
      $display("FAIL sat_set_wins: got %b want 1", s_flag);
      errors++;
    end
  endtask

  // SHIFT=8 with a single stage: 300^2>>8 = 351 and (-32768)^2>>8 = 4194304.
  task automatic test_shift;
    h_sv = 1'b1; h_sd = 16'd300; step;
    h_sv = 1'b0;
    checks++;
    if (h_mv !== 1'b1 || h_md !== 32'd351) begin
      $display("FAIL shift_300: got v=%b d=%0d, want v=1 d=351", h_mv, h_md);
      errors++;
    end
    h_sv = 1'b1; h_sd = 16'h8000; step;
    h_sv = 1'b0;
    checks++;
    if (h_mv !== 1'b1 || h_md !== 32'd4194304) begin
      $display("FAIL shift_mostneg: got v=%b d=%0d, want v=1 d=4194304", h_mv, h_md);
      errors++;
    end
    step;
    checks++;
    if (h_mv !== 1'b0 || h_flag !== 1'b0) begin
      $display("FAIL shift_drain: got v=%b f=%b, want v=0 f=0", h_mv, h_flag);
      errors++;
    end
  endtask

  // Reset is asserted while two beats are in flight and the output is stalled.
  task automatic test_reset_mid;
    int seen;
    d_mr = 1'b0;
    d_sv = 1'b1; d_sd = 16'd11; step;
    d_sd = 16'd12; step;
    d_sv = 1'b0;
    checks++;
    if (d_mv !== 1'b1 || d_md !== 32'd121 || d_sr !== 1'b0) begin
      $display("FAIL rstmid_pre: got v=%b d=%0d r=%b, want v=1 d=121 r=0", d_mv, d_md, d_sr);
      errors++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_mv !== 1'b0 || d_md !== 32'd0) begin
      $display("FAIL rstmid_async: got v=%b d=%0d, want v=0 d=0", d_mv, d_md);
      errors++;
    end
    step;
    rst_n = 1'b1;
    d_mr = 1'b1;
    d_sv = 1'b1; d_sd = 16'd3; step;
    d_sv = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (d_mv === 1'b1) begin
        seen++;
        checks++;
        if (d_md !== 32'd9) begin
          $display("FAIL rstmid_data: got %0d want 9", d_md);
          errors++;
        end
      end
      step;
    end
    checks++;
    if (seen != 1) begin
      $display("FAIL rstmid_count: got %0d beats want 1", seen);
      errors++;
    end
  endtask

  initial begin
    d_sv = 1'b0; d_sd = '0; d_mr = 1'b1; d_clr = 1'b0; d_sl = 1'b0;
    s_sv = 1'b0; s_sd = '0; s_mr = 1'b1; s_clr = 1'b0; s_sl = 1'b0;
    h_sv = 1'b0; h_sd = '0; h_mr = 1'b1; h_clr = 1'b0; h_sl = 1'b0;
    test_reset;
    test_gaps;
    test_back_to_back;
    test_stall;
    test_saturation;
    test_shift;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
